// File: rtl/counter_pkg.sv
// Shared types and constants for the 4-bit up-counter slice.
// Every other file imports this package.
package counter_pkg;

  localparam int unsigned CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/counter_4bit_up_if.sv
// Control and status bundle between a counter stage and whatever drives it.
// The master modport drives the controls; the slave modport is the counter itself.
interface counter_4bit_up_if
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;

  modport master (
    output en,
    output load,
    output load_val,
    input  count,
    input  tc
  );

  modport slave (
    input  en,
    input  load,
    input  load_val,
    output count,
    output tc
  );

endinterface

// File: rtl/counter_4bit_next.sv
// Combinational next-state and terminal-count logic for the up-counter.
// The priority is load, then increment, then hold.
module counter_4bit_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_d_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] MaxVal = {WIDTH{1'b1}};

  always_comb begin
    count_d_o = count_i;
    if (load_i) begin
      count_d_o = load_val_i;
    end else if (en_i) begin
      count_d_o = count_i + WIDTH'(1);
    end
  end

  // tc follows en even while loading; a cascaded stage gates on load itself if it needs to.
  assign tc_o = en_i && (count_i == MaxVal);

endmodule

// File: rtl/counter_4bit_up.sv
// Top level of the 4-bit up-counter: the asynchronous-reset count register plus wiring.
// The count output comes straight from the register.
module counter_4bit_up
  import counter_pkg::*;
#(
  parameter int unsigned           WIDTH     = CNT_W,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  counter_4bit_up_if.slave   bus_io
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_raw;

  counter_4bit_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .count_i    (count_q),
    .en_i       (bus_io.en),
    .load_i     (bus_io.load),
    .load_val_i (bus_io.load_val),
    .count_d_o  (count_d),
    .tc_o       (tc_raw)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus_io.count = count_q;
  // Mask tc during reset, so it stays low even when RESET_VAL is all ones.
  assign bus_io.tc    = tc_raw & rst_ni;

`ifndef SYNTHESIS
  load_takes_value_a : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    bus_io.load |=> (count_q == $past(bus_io.load_val))
  );
`endif

endmodule

// File: tb/tb_counter_4bit_up.sv
// Directed bench for counter_4bit_up: a table of vectors plus hand-written
// sequences for reset behaviour.
module tb_counter_4bit_up;
  import counter_pkg::*;

  typedef struct {
    logic en;
    logic load;
    cnt_t load_val;
    logic tc_exp;   // tc before the edge
    cnt_t cnt_exp;  // count after the edge
  } vec_t;

  logic clk_i;
  logic rst_ni;
  int   pass_cnt;
  int   total_cnt;
  vec_t vecs[$];

  counter_4bit_up_if #(.WIDTH(CNT_W)) bus ();

  counter_4bit_up #(
    .WIDTH     (CNT_W),
    .RESET_VAL (4'h0)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus_io (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic en, logic load, cnt_t lv, logic tc, cnt_t cnt);
    vec_t v;
    v.en       = en;
    v.load     = load;
    v.load_val = lv;
    v.tc_exp   = tc;
    v.cnt_exp  = cnt;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;

    // Release into counting: 1..15, then tc high at 15 and wrap to 0.
    for (int i = 1; i <= 15; i++) vecs.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, cnt_t'(i)));
    vecs.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 4'h0));
    // Hold at 5 for three edges, then resume to 6.
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, cnt_t'(i)));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 4'h5));
    vecs.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h6));
    // Load priority from 3: load C with en high gives 12, then 13,14,15,0.
    vecs.push_back(mk(1'b0, 1'b1, 4'h3, 1'b0, 4'h3));
    vecs.push_back(mk(1'b1, 1'b1, 4'hC, 1'b0, 4'hC));
    vecs.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'hD));
    vecs.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'hE));
    vecs.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'hF));
    vecs.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 4'h0));
    // tc still reflects en while loading at 15.
    vecs.push_back(mk(1'b0, 1'b1, CNT_MAX, 1'b0, 4'hF));
    vecs.push_back(mk(1'b1, 1'b1, 4'h7, 1'b1, 4'h7));
    // tc gating: 15 with en low holds and tc stays low; en high raises tc, then wraps.
    vecs.push_back(mk(1'b0, 1'b1, CNT_MAX, 1'b0, 4'hF));
    vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 4'hF));
    vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 4'hF));
    vecs.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 4'h0));

    // Reset held across edges with en high.
    rst_ni       = 1'b0;
    bus.en       = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = 4'h0;
    #2;
    check("rst_count_t2", 32'(bus.count), 32'h0);
    check("rst_tc_t2", 32'(bus.tc), 32'h0);
    tick();
    check("rst_count_e1", 32'(bus.count), 32'h0);
    check("rst_tc_e1", 32'(bus.tc), 32'h0);
    tick();
    check("rst_count_e2", 32'(bus.count), 32'h0);
    check("rst_tc_e2", 32'(bus.tc), 32'h0);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      bus.en       = vecs[i].en;
      bus.load     = vecs[i].load;
      bus.load_val = vecs[i].load_val;
      #1;
      check($sformatf("vec%0d_tc", i), 32'(bus.tc), 32'(vecs[i].tc_exp));
      tick();
      check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].cnt_exp));
    end

    // Asynchronous reset mid-run at 9, between edges.
    bus.en       = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 4'h9;
    tick();
    check("ar_loaded", 32'(bus.count), 32'h9);
    bus.load = 1'b0;
    #3;
    rst_ni = 1'b0;
    #1;
    check("ar_count_now", 32'(bus.count), 32'h0);
    check("ar_tc_now", 32'(bus.tc), 32'h0);
    tick();
    check("ar_hold_e1", 32'(bus.count), 32'h0);
    tick();
    check("ar_hold_e2", 32'(bus.count), 32'h0);
    #2;
    rst_ni = 1'b1;
    tick();
    check("ar_resume1", 32'(bus.count), 32'h1);
    tick();
    check("ar_resume2", 32'(bus.count), 32'h2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
